// File: rtl/filter2d_in_buf.sv
// filter2d_in_buf: input frame buffer feeding the 3x3 filter2d stage.
// Loads one WIDTH x WIDTH 8-bit frame from the host stream, pulses start,
// serves the filter's 1-cycle-latency reads and counts the filter's output
// strobes to detect end of frame.
// Optional: define FILTER2D_IN_BUF_DBL_EN for ping-pong banks, which lets
// the next frame load while the filter processes the current one.
module filter2d_in_buf #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_strb,
  input  logic              i_sof,
  input  logic [7:0]        i_data,
  output logic              i_ready,
  output logic              start,
  input  logic              mem_rd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              f_strb,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf_err
);

  localparam int unsigned N = WIDTH * WIDTH;
`ifdef FILTER2D_IN_BUF_DBL_EN
  localparam int unsigned BANKS = 2;
  localparam logic READY_IN_PROC = 1'b1;
`else
  localparam int unsigned BANKS = 1;
  localparam logic READY_IN_PROC = 1'b0;
`endif
  localparam int unsigned DEPTH  = BANKS * N;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] N_C    = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0] LAST_C = (ADDR_W + 1)'(N - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] KICK = 3'd2;
  localparam logic [2:0] PROC = 3'd3;
  localparam logic [2:0] PEND = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   wr_cnt_nxt;
  logic [ADDR_W:0]   out_cnt;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_ext;
  logic              loading;
  logic              accept;
  logic              drop;
  logic              load_last;
  logic              filt_last;
  logic              count_en;
  logic              rd_in_range;
  logic [MEM_AW-1:0] wr_base;
  logic [MEM_AW-1:0] rd_base;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic [7:0]        mem [DEPTH];

`ifdef FILTER2D_IN_BUF_DBL_EN
  localparam logic [MEM_AW-1:0] BANK_OFS = MEM_AW'(N);
  logic wr_bank;

  // Write bank flips as a frame is handed over; the filter reads the other bank.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_bank <= 1'b0;
    end else if (state == KICK) begin
      wr_bank <= ~wr_bank;
    end
  end

  assign wr_base = wr_bank ? BANK_OFS : '0;
  assign rd_base = wr_bank ? '0 : BANK_OFS;
`else
  assign wr_base = '0;
  assign rd_base = '0;
`endif

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    i_ready = 1'b0;
    start   = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE, LOAD: i_ready = 1'b1;
      KICK:       start   = 1'b1;
      PROC: begin
        busy    = 1'b1;
        i_ready = READY_IN_PROC;
      end
      PEND:       busy    = ~frame_done;
      default: ;
    endcase
  end

  // A load is in progress whenever the write counter is non-zero, so a
  // non-sof strobe is only accepted mid-frame.
  assign loading     = (wr_cnt != '0);
  assign accept      = i_strb & i_ready & (i_sof | loading);
  assign drop        = i_strb & ~accept;
  assign wr_addr     = i_sof ? '0 : wr_cnt;
  assign load_last   = accept & (wr_addr == LAST_C);
  assign count_en    = (state == PROC) | ((state == PEND) & ~frame_done);
  assign filt_last   = count_en & f_strb & (out_cnt == LAST_C);
  assign wr_idx      = wr_base + wr_addr[MEM_AW-1:0];
  assign rd_ext      = {1'b0, rd_addr};
  assign rd_in_range = (rd_ext < N_C);
  assign rd_idx      = rd_base + rd_ext[MEM_AW-1:0];

  // Next write counter: restart on sof, clear once the frame is complete.
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    if (accept) begin
      wr_cnt_nxt = load_last ? '0 : wr_addr + 1'b1;
    end
  end

  // Frame FSM, output strobe counter, end-of-frame pulse and overflow flag.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      wr_cnt     <= wr_cnt_nxt;
      frame_done <= 1'b0;

      if (drop) begin
        ovf_err <= 1'b1;
      end else if (accept & i_sof) begin
        ovf_err <= 1'b0;
      end

      if (count_en & f_strb) begin
        if (filt_last) begin
          out_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end

      // PROC only accepts writes in double-bank builds, so the PEND and
      // PROC->LOAD paths are unreachable in the single-bank build.
      case (state)
        IDLE: begin
          if (load_last) begin
            state <= KICK;
          end else if (accept) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (load_last) begin
            state <= KICK;
          end
        end
        KICK: state <= PROC;
        PROC: begin
          if (load_last) begin
            state <= PEND;
          end else if (filt_last) begin
            state <= (wr_cnt_nxt != '0) ? LOAD : IDLE;
          end
        end
        PEND: begin
          if (frame_done) begin
            state <= KICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host write port; RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= i_data;
    end
  end

  // Filter read port: out-of-range addresses return zero, data holds when idle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_data <= '0;
    end else if (mem_rd) begin
      rd_data <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_filter2d_in_buf.sv
// tb_filter2d_in_buf: randomized self-checking bench for filter2d_in_buf
// with WIDTH=4 (16-pixel frames). Expected values come from a frame-level
// model: an array of pixels written so far plus simple pixel/strobe counts.
module tb_filter2d_in_buf;

  localparam int unsigned NPIX = 16;
`ifdef FILTER2D_IN_BUF_DBL_EN
  localparam logic READY_PROC = 1'b1;
`else
  localparam logic READY_PROC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        i_strb = 1'b0;
  logic        i_sof = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_ready;
  logic        start;
  logic        mem_rd = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        f_strb = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        ovf_err;

  int   n_vec = 0;
  int   n_err = 0;
  logic ovf_exp = 1'b0;
  logic [7:0] ref_mem [NPIX];
  logic [7:0] ref_b   [NPIX];

  filter2d_in_buf #(
    .WIDTH  (4),
    .ADDR_W (16)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_strb     (i_strb),
    .i_sof      (i_sof),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .start      (start),
    .mem_rd     (mem_rd),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .f_strb     (f_strb),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 16'($urandom_range(0, 15));
      2:       return 16'($urandom_range(16, 255));
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic do_read(input logic [15:0] a);
    logic [7:0] e;
    e = (a < 16'd16) ? ref_mem[a[3:0]] : 8'd0;
    mem_rd = 1'b1;
    rd_addr = a;
    step();
    mem_rd = 1'b0;
    check_val("rd_data", 32'(rd_data), 32'(e));
    rd_addr = 16'($urandom);
    step();
    check_val("rd_hold", 32'(rd_data), 32'(e));
  endtask

  // Loads a full frame from IDLE; restart_at >= 0 re-asserts sof at that pixel.
  task automatic load_frame(input bit ramp, input int restart_at);
    int         addr;
    int         total;
    logic [7:0] d;
    bit         sof;
    addr  = 0;
    total = (restart_at > 0) ? NPIX + restart_at : NPIX;
    for (int i = 0; i < total; i++) begin
      sof = (i == 0) || (i == restart_at);
      if (sof) addr = 0;
      d = ramp ? 8'(addr) : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin
        step();
        check_val("gap_start", 32'(start), 32'd0);
        check_val("gap_ready", 32'(i_ready), 32'd1);
      end
      i_strb = 1'b1;
      i_sof  = sof;
      i_data = d;
      step();
      i_strb = 1'b0;
      i_sof  = 1'b0;
      ref_mem[addr] = d;
      addr++;
      if (sof) ovf_exp = 1'b0;
      check_val("ovf_load", 32'(ovf_err), 32'(ovf_exp));
      if (addr == NPIX) begin
        check_val("start_last", 32'(start), 32'd1);
        check_val("ready_kick", 32'(i_ready), 32'd0);
        check_val("busy_kick", 32'(busy), 32'd0);
      end else begin
        check_val("start_early", 32'(start), 32'd0);
        check_val("ready_load", 32'(i_ready), 32'd1);
      end
    end
    step();
    check_val("start_pulse", 32'(start), 32'd0);
    check_val("busy_proc", 32'(busy), 32'd1);
    check_val("ready_proc", 32'(i_ready), 32'(READY_PROC));
  endtask

  // Issues NPIX filter strobes with random gaps while in PROC.
  task automatic run_filter();
    for (int k = 1; k <= NPIX; k++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        check_val("fgap_busy", 32'(busy), 32'd1);
        check_val("fgap_done", 32'(frame_done), 32'd0);
      end
      f_strb = 1'b1;
      step();
      f_strb = 1'b0;
      if (k == NPIX) begin
        check_val("done_pulse", 32'(frame_done), 32'd1);
        check_val("done_busy", 32'(busy), 32'd0);
        check_val("done_ready", 32'(i_ready), 32'd1);
      end else begin
        check_val("fs_done", 32'(frame_done), 32'd0);
        check_val("fs_busy", 32'(busy), 32'd1);
        check_val("fs_ready", 32'(i_ready), 32'(READY_PROC));
      end
    end
    step();
    check_val("done_clear", 32'(frame_done), 32'd0);
  endtask

  task automatic proc_stray();
    i_strb = 1'b1;
    i_sof  = 1'b0;
    i_data = 8'hAA;
    step();
    i_strb = 1'b0;
    ovf_exp = 1'b1;
    check_val("ovf_proc", 32'(ovf_err), 32'd1);
    check_val("busy_stray", 32'(busy), 32'd1);
    do_read(16'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ref_mem[i] = '0;
      ref_b[i]   = '0;
    end

    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    check_val("rst_ready", 32'(i_ready), 32'd1);
    check_val("rst_start", 32'(start), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);
    check_val("rst_ovf", 32'(ovf_err), 32'd0);

    // Stray non-sof pixel in IDLE is dropped and flagged.
    i_strb = 1'b1;
    i_data = 8'h55;
    step();
    i_strb = 1'b0;
    ovf_exp = 1'b1;
    check_val("ovf_idle", 32'(ovf_err), 32'd1);
    check_val("ready_idle", 32'(i_ready), 32'd1);

    // Ramp frame, boundary reads, overflow during processing.
    load_frame(1'b1, -1);
    do_read(16'd5);
    do_read(16'd16);
    do_read(16'hFFFF);
    do_read(16'd15);
    for (int i = 0; i < 4; i++) do_read(pick_addr());
    proc_stray();
    run_filter();

    // Filter strobes outside processing are ignored.
    for (int i = 0; i < 3; i++) begin
      f_strb = 1'b1;
      step();
      f_strb = 1'b0;
      check_val("idle_fs_done", 32'(frame_done), 32'd0);
      check_val("idle_fs_busy", 32'(busy), 32'd0);
    end

    // Random frames, first one restarted with sof at pixel 7.
    for (int r = 0; r < 4; r++) begin
      load_frame(1'b0, (r == 0) ? 7 : int'($urandom_range(0, 20)) - 5);
      do_read(16'd0);
      for (int i = 0; i < 5; i++) do_read(pick_addr());
      if (r[0]) proc_stray();
      run_filter();
    end

`ifdef FILTER2D_IN_BUF_DBL_EN
    // Frame B loads into the free bank while frame A is processed.
    load_frame(1'b0, -1);
    for (int i = 0; i < NPIX; i++) begin
      i_strb = 1'b1;
      i_sof  = (i == 0);
      i_data = 8'(100 + i);
      step();
      i_strb = 1'b0;
      i_sof  = 1'b0;
      ref_b[i] = 8'(100 + i);
      check_val("dbl_ready", 32'(i_ready), 32'(i < NPIX - 1));
      check_val("dbl_start", 32'(start), 32'd0);
      check_val("dbl_busy", 32'(busy), 32'd1);
    end
    ovf_exp = 1'b0;
    check_val("dbl_ovf", 32'(ovf_err), 32'd0);
    do_read(16'd3);
    for (int k = 1; k <= NPIX; k++) begin
      f_strb = 1'b1;
      step();
      f_strb = 1'b0;
      check_val("pend_done", 32'(frame_done), 32'(k == NPIX));
      check_val("pend_busy", 32'(busy), 32'(k < NPIX));
      check_val("pend_ready", 32'(i_ready), 32'd0);
      check_val("pend_start", 32'(start), 32'd0);
    end
    step();
    check_val("dbl_kick", 32'(start), 32'd1);
    step();
    check_val("dbl_kick_end", 32'(start), 32'd0);
    check_val("dbl_proc_busy", 32'(busy), 32'd1);
    ref_mem = ref_b;
    do_read(16'd0);
    do_read(16'd15);
    run_filter();
`endif

    // Reset in the middle of a load aborts the partial frame.
    for (int i = 0; i < 5; i++) begin
      i_strb = 1'b1;
      i_sof  = (i == 0);
      i_data = 8'($urandom_range(0, 255));
      step();
    end
    i_strb = 1'b0;
    i_sof  = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    check_val("mid_rst_ready", 32'(i_ready), 32'd1);
    check_val("mid_rst_start", 32'(start), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_rd", 32'(rd_data), 32'd0);
    check_val("mid_rst_ovf", 32'(ovf_err), 32'd0);
    @(posedge clk);
    #1 n_reset = 1'b1;
    ovf_exp = 1'b0;
    load_frame(1'b0, -1);
    do_read(pick_addr());
    run_filter();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
